// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared state encoding and timing constants for the UART TX scheduler.
package uart_tx_sched_pkg;
    localparam int DATA_W = 8;
    localparam int TIMEOUT_CYCLES = 3;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;
endpackage

// File: rtl/uart_tx_sched_rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant; i_prio1 says which requester wins a tie.
module rr_arbiter_2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_prio1,
    output logic o_gnt0,
    output logic o_gnt1
);
    assign o_gnt0 = i_req0 & (~i_req1 | ~i_prio1);
    assign o_gnt1 = i_req1 & (~i_req0 | i_prio1);
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: arbitrates a byte source and a word source onto one UART transmitter,
// strobing one byte at a time and flagging a transmitter that never goes busy.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req0,
    input  logic [DATA_W-1:0]     i_req0_data,
    output logic                  o_ack0,
    input  logic                  i_req1,
    input  logic [2*DATA_W-1:0]   i_req1_data,
    output logic                  o_ack1,
    input  logic                  i_cfg_par_en,
    input  logic                  i_cfg_par_typ,
    input  logic                  i_tx_busy,
    output logic [DATA_W-1:0]     o_tx_p_data,
    output logic                  o_tx_d_vld,
    output logic                  o_tx_par_en,
    output logic                  o_tx_par_typ,
    output logic                  o_sched_busy,
    output logic                  o_timeout_err
);
    state_t              r_state, w_state;
    logic [1:0]          r_bytes_left, w_bytes_left;
    logic [DATA_W-1:0]   r_hi, w_hi;
    logic [1:0]          r_cnt, w_cnt;
    logic                r_owner, w_owner;
    logic                r_prio1, w_prio1;
    logic                w_ack0, w_ack1, w_tx_d_vld, w_par_en, w_par_typ, w_sched_busy, w_err;
    logic [DATA_W-1:0]   w_tx_p_data;
    logic                w_gnt0, w_gnt1;

    rr_arbiter_2 u_arb (
        .i_req0  (i_req0),
        .i_req1  (i_req1),
        .i_prio1 (r_prio1),
        .o_gnt0  (w_gnt0),
        .o_gnt1  (w_gnt1)
    );

    always_comb begin
        w_state      = r_state;
        w_bytes_left = r_bytes_left;
        w_hi         = r_hi;
        w_cnt        = r_cnt;
        w_owner      = r_owner;
        w_prio1      = r_prio1;
        w_ack0       = 1'b0;
        w_ack1       = 1'b0;
        w_tx_d_vld   = 1'b0;
        w_tx_p_data  = o_tx_p_data;
        w_par_en     = o_tx_par_en;
        w_par_typ    = o_tx_par_typ;
        w_sched_busy = o_sched_busy;
        w_err        = o_timeout_err;
        case (r_state)
            IDLE: if (!i_tx_busy && (w_gnt0 || w_gnt1)) begin
                w_state      = LOAD;
                w_bytes_left = w_gnt1 ? 2'd2 : 2'd1;
                w_hi         = w_gnt1 ? i_req1_data[2*DATA_W-1:DATA_W] : '0;
                w_owner      = w_gnt1;
                w_ack0       = w_gnt0;
                w_ack1       = w_gnt1;
                w_tx_d_vld   = 1'b1;
                w_tx_p_data  = w_gnt1 ? i_req1_data[DATA_W-1:0] : i_req0_data;
                w_par_en     = i_cfg_par_en;
                w_par_typ    = i_cfg_par_typ;
                w_sched_busy = 1'b1;
            end
            LOAD: begin
                w_state = WAIT_HI;
                w_cnt   = 2'd0;
            end
            // Transmitter must raise busy within TIMEOUT_CYCLES, else drop the rest.
            WAIT_HI: if (i_tx_busy) begin
                w_state = WAIT_LO;
            end else if (r_cnt == 2'(TIMEOUT_CYCLES - 1)) begin
                w_state      = IDLE;
                w_err        = 1'b1;
                w_bytes_left = 2'd0;
                w_prio1      = ~r_owner;
                w_sched_busy = 1'b0;
            end else begin
                w_cnt = r_cnt + 2'd1;
            end
            WAIT_LO: if (!i_tx_busy) begin
                w_bytes_left = r_bytes_left - 2'd1;
                if (r_bytes_left > 2'd1) begin
                    w_state     = LOAD;
                    w_tx_d_vld  = 1'b1;
                    w_tx_p_data = r_hi;
                end else begin
                    w_state      = IDLE;
                    w_prio1      = ~r_owner;
                    w_sched_busy = 1'b0;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_bytes_left  <= '0;
            r_hi          <= '0;
            r_cnt         <= '0;
            r_owner       <= 1'b0;
            r_prio1       <= 1'b0;
            o_ack0        <= 1'b0;
            o_ack1        <= 1'b0;
            o_tx_d_vld    <= 1'b0;
            o_tx_p_data   <= '0;
            o_tx_par_en   <= 1'b0;
            o_tx_par_typ  <= 1'b0;
            o_sched_busy  <= 1'b0;
            o_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_bytes_left  <= w_bytes_left;
            r_hi          <= w_hi;
            r_cnt         <= w_cnt;
            r_owner       <= w_owner;
            r_prio1       <= w_prio1;
            o_ack0        <= w_ack0;
            o_ack1        <= w_ack1;
            o_tx_d_vld    <= w_tx_d_vld;
            o_tx_p_data   <= w_tx_p_data;
            o_tx_par_en   <= w_par_en;
            o_tx_par_typ  <= w_par_typ;
            o_sched_busy  <= w_sched_busy;
            o_timeout_err <= w_err;
        end
    end
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Data_width, 8, width of one UART frame payload.
REQ-002 CLK  in  1  single clock; all state updates on the rising edge.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 REQ0  in  1  requester 0 (byte source) request; level, held until ACK0.
REQ-005 REQ0_DATA  in  Data_width  byte; stable while REQ0=1.
REQ-006 ACK0  out  1  one-cycle accept pulse to requester 0.
REQ-007 REQ1  in  1  requester 1 (word source) request; level, held until ACK1.
REQ-008 REQ1_DATA  in  2*Data_width  word; stable while REQ1=1.
REQ-009 ACK1  out  1  one-cycle accept pulse to requester 1.
REQ-010 CFG_PAR_EN  in  1  parity enable configuration.
REQ-011 CFG_PAR_TYP  in  1  parity type configuration.
REQ-012 TX_BUSY  in  1  Busy from the UART transmitter.
REQ-013 TX_P_DATA  out  Data_width  byte presented to the transmitter.
REQ-014 TX_D_VLD  out  1  one-cycle data-valid strobe to the transmitter.
REQ-015 TX_PAR_EN  out  1  parity enable to the transmitter.
REQ-016 TX_PAR_TYP  out  1  parity type to the transmitter.
REQ-017 SCHED_BUSY  out  1  high whenever a transaction is in progress.
REQ-018 TIMEOUT_ERR  out  1  sticky error; transmitter did not acknowledge a strobe.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, WAIT_HI and WAIT_LO; all outputs registered.
REQ-020 IDLE SHALL grant only when TX_BUSY=0 and at least one REQ is high.
REQ-021 On grant: capture data, set bytes_left (1 for REQ0, 2 for REQ1), latch CFG_PAR_EN/TYP, pulse the matching ACK next cycle, go LOAD.
REQ-022 Ties SHALL be broken round-robin: the requester not served last wins; after reset requester 0 wins.
REQ-023 A REQ still high in its ACK cycle SHALL NOT be re-granted in that transaction.
REQ-024 LOAD SHALL last exactly one cycle, with TX_D_VLD=1 and TX_P_DATA=current byte, then go WAIT_HI.
REQ-025 Word order: REQ1_DATA[Data_width-1:0] first, then REQ1_DATA[2*Data_width-1:Data_width].
REQ-026 WAIT_HI SHALL wait for TX_BUSY=1, for at most TIMEOUT_CYCLES=3 cycles.
REQ-027 On timeout: set TIMEOUT_ERR, abandon remaining bytes, update the round-robin pointer, go IDLE.
REQ-028 WAIT_LO SHALL wait for TX_BUSY=0, then decrement bytes_left.
REQ-029 After WAIT_LO: if bytes remain, go LOAD; else update the round-robin pointer and go IDLE.
REQ-030 TX_P_DATA SHALL hold its last value between strobes.
REQ-031 TX_PAR_EN/TYP SHALL stay constant for a whole transaction; CFG changes mid-transaction apply to the next one.
REQ-032 SCHED_BUSY SHALL be 1 in every state except IDLE.
REQ-033 TIMEOUT_ERR SHALL be cleared only by RST.

Reset
REQ-034 RST SHALL force IDLE, bytes_left=0, round-robin pointer to favour requester 0, and clear TIMEOUT_ERR.
REQ-035 RST SHALL drive all outputs to 0, including TX_P_DATA and both ACKs.
REQ-036 Reset mid-transaction SHALL discard pending bytes with no ACK and no further TX_D_VLD.

Structure
REQ-037 The shared package SHALL hold the 2-bit state encoding and the TIMEOUT_CYCLES constant.
REQ-038 Round-robin selection SHALL be a sub-module, rr_arbiter_2.

Verification
REQ-039 REQ0=1, data 0xA5, TX_BUSY modelled 1 for 10 cycles after the strobe -> ACK0 one cycle, one TX_D_VLD with 0xA5, SCHED_BUSY falls after TX_BUSY falls.
REQ-040 REQ1=1, data 0x1234 -> ACK1; strobes with 0x34 then 0x12, second strobe only after TX_BUSY returns 0.
REQ-041 REQ0 and REQ1 high together after reset -> requester 0 first; both high again -> requester 1 first.
REQ-042 TX_BUSY held 0 after the strobe -> TIMEOUT_ERR=1 three cycles later, FSM IDLE, error sticky until RST.
REQ-043 RST asserted between the two bytes of 0xBEEF -> outputs 0, no 0xBE strobe, next grant favours requester 0.
REQ-044 CFG_PAR_EN toggled 1->0 mid-word -> TX_PAR_EN stays 1 for both bytes, is 0 for the next transaction.
